// File: rtl/accel_smoother_if.sv
// accel_smoother_if
// Groups the sample-in and filtered-out signals of the accelerometer smoother.
//   in_valid        : one-cycle pulse, a raw sample is present on in_x/in_y/in_z
//   in_x/in_y/in_z  : raw signed 16-bit axis samples
//   out_valid       : one-cycle pulse, out_x/out_y/out_z have just been updated
//   out_x/y/z       : signed moving-average results
//   filled          : the averaging window holds only real samples
//   motion          : the filtered output moved by more than the threshold on the last update
//   overrun         : sticky, a sample arrived while the smoother was busy and was dropped
// Modport master drives samples (accelerometer controller side).
// Modport slave is used by the smoother itself.
interface accel_smoother_if;
    logic               in_valid;
    logic signed [15:0] in_x;
    logic signed [15:0] in_y;
    logic signed [15:0] in_z;
    logic               out_valid;
    logic signed [15:0] out_x;
    logic signed [15:0] out_y;
    logic signed [15:0] out_z;
    logic               filled;
    logic               motion;
    logic               overrun;

    modport master (
        output in_valid, in_x, in_y, in_z,
        input  out_valid, out_x, out_y, out_z, filled, motion, overrun
    );

    modport slave (
        input  in_valid, in_x, in_y, in_z,
        output out_valid, out_x, out_y, out_z, filled, motion, overrun
    );
endinterface

// File: rtl/accel_smoother.sv
// accel_smoother
// Three-axis moving-average filter for raw accelerometer samples. Each accepted
// sample is folded into a per-axis circular window of 2^DEPTH_LOG2 entries, one
// axis per cycle, and the averaged result is published with a one-cycle
// out_valid pulse. A motion flag reports large steps in the filtered output.
// Ports:
//   spi_clk : clock, rising edge
//   n_rst   : asynchronous active-low reset
//   bus     : accel_smoother_if.slave (sample in, filtered results and status out)
module accel_smoother #(
    parameter int          DEPTH_LOG2    = 3,
    parameter logic [15:0] MOTION_THRESH = 16'd64
) (
    input  logic             spi_clk,
    input  logic             n_rst,
    accel_smoother_if.slave  bus
);

    localparam int WINDOW = 1 << DEPTH_LOG2;
    localparam int SUM_W  = 16 + DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        AX,
        AY,
        AZ,
        EMIT
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [15:0]      hold_x, hold_y, hold_z;
    logic signed [15:0]      buf_x [WINDOW];
    logic signed [15:0]      buf_y [WINDOW];
    logic signed [15:0]      buf_z [WINDOW];
    logic signed [SUM_W-1:0] sum_x, sum_y, sum_z;
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [CNT_W-1:0]        count;

    logic signed [15:0]      avg_x, avg_y, avg_z;
    logic                    window_full;
    logic                    step_big;

    // The sum carries DEPTH_LOG2 extra bits, so the arithmetic shift always
    // lands back inside 16 bits; >>> floors toward minus infinity.
    assign avg_x = 16'(sum_x >>> DEPTH_LOG2);
    assign avg_y = 16'(sum_y >>> DEPTH_LOG2);
    assign avg_z = 16'(sum_z >>> DEPTH_LOG2);

    assign window_full = (count == CNT_W'(WINDOW));
    assign bus.filled  = window_full;

    // Step size is taken at 17 bits so a full-range swing cannot wrap.
    function automatic logic exceeds(input logic signed [15:0] now_val,
                                     input logic signed [15:0] prev_val);
        logic signed [16:0] diff;
        logic        [16:0] mag;
        diff = 17'(now_val) - 17'(prev_val);
        mag  = diff[16] ? -diff : diff;
        return mag > {1'b0, MOTION_THRESH};
    endfunction

    assign step_big = exceeds(avg_x, bus.out_x) ||
                      exceeds(avg_y, bus.out_y) ||
                      exceeds(avg_z, bus.out_z);

    always_ff @(posedge spi_clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = AX;
            AX:      next_state = AY;
            AY:      next_state = AZ;
            AZ:      next_state = EMIT;
            EMIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: each axis swaps its oldest window entry for the new sample in
    // its own state, so only one buffer is written per cycle. Empty slots start
    // at zero, which biases the average toward zero until the window fills.
    always_ff @(posedge spi_clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_x        <= '0;
            hold_y        <= '0;
            hold_z        <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                buf_x[i] <= '0;
                buf_y[i] <= '0;
                buf_z[i] <= '0;
            end
            sum_x         <= '0;
            sum_y         <= '0;
            sum_z         <= '0;
            wptr          <= '0;
            count         <= '0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_z     <= '0;
            bus.out_valid <= 1'b0;
            bus.motion    <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid && state != IDLE) begin
                bus.overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        hold_x <= bus.in_x;
                        hold_y <= bus.in_y;
                        hold_z <= bus.in_z;
                    end
                end
                AX: begin
                    sum_x       <= sum_x + SUM_W'(hold_x) - SUM_W'(buf_x[wptr]);
                    buf_x[wptr] <= hold_x;
                end
                AY: begin
                    sum_y       <= sum_y + SUM_W'(hold_y) - SUM_W'(buf_y[wptr]);
                    buf_y[wptr] <= hold_y;
                end
                AZ: begin
                    sum_z       <= sum_z + SUM_W'(hold_z) - SUM_W'(buf_z[wptr]);
                    buf_z[wptr] <= hold_z;
                end
                EMIT: begin
                    bus.out_x     <= avg_x;
                    bus.out_y     <= avg_y;
                    bus.out_z     <= avg_z;
                    bus.out_valid <= 1'b1;
                    // Motion is only meaningful once the previous output was a full-window average.
                    bus.motion    <= window_full && step_big;
                    wptr          <= wptr + DEPTH_LOG2'(1);
                    if (!window_full) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/accel_smoother.md
ACCEL_SMOOTHER -- requirements
Module: accel_smoother

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, log2 of moving-average window length (window = 2^DEPTH_LOG2 samples, legal 1..5).
REQ-002 Parameter MOTION_THRESH, default 16'd64, unsigned per-axis threshold on filtered-output change.
REQ-003 spi_clk  input  1  clock; all logic on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  single-cycle pulse, new raw sample present on in_x/in_y/in_z.
REQ-006 in_x, in_y, in_z  input  16 each  raw signed two's-complement axis samples from the accelerometer controller.
REQ-007 out_valid  output  1  single-cycle pulse, filtered outputs updated.
REQ-008 out_x, out_y, out_z  output  16 each  signed moving-average results.
REQ-009 filled  output  1  window holds 2^DEPTH_LOG2 real samples.
REQ-010 motion  output  1  filtered change exceeded MOTION_THRESH on the latest update.
REQ-011 overrun  output  1  sticky; a sample arrived while busy and was dropped.

Function
REQ-012 FSM states: IDLE, AX, AY, AZ, EMIT; IDLE->AX on in_valid, AX->AY->AZ->EMIT unconditionally, EMIT->IDLE.
REQ-013 On in_valid in IDLE, the three inputs shall be captured into holding registers; in_x/y/z are not sampled at any other time.
REQ-014 Per axis, a 2^DEPTH_LOG2-entry circular buffer and signed running sum of width 16+DEPTH_LOG2 bits shall be kept; no overflow possible.
REQ-015 In AX (resp. AY, AZ): sum <= sum + new - buf[wptr]; buf[wptr] <= new, for that axis only.
REQ-016 In EMIT: out_* <= sum_* arithmetically shifted right by DEPTH_LOG2 (floor toward minus infinity); out_valid = 1 for this cycle only.
REQ-017 In EMIT: wptr increments, wrapping from 2^DEPTH_LOG2-1 to 0; sample count increments, saturating at 2^DEPTH_LOG2.
REQ-018 filled shall rise in the same cycle as the out_valid of the 2^DEPTH_LOG2-th accepted sample and stay high until reset.
REQ-019 Latency: in_valid at cycle N -> out_valid at cycle N+4; throughput max one sample per 5 cycles.
REQ-020 Before filled, empty buffer slots count as zero (average biased toward 0); this is required behaviour.
REQ-021 motion shall update only in EMIT: 1 if filled was already 1 before this EMIT and |new out_a - previous out_a| > MOTION_THRESH for any axis a, else 0; difference computed at 17 bits signed.
REQ-022 motion holds its value between EMIT cycles.
REQ-023 in_valid while state != IDLE: sample dropped, no state change, overrun <= 1; overrun clears only on reset.
REQ-024 in_valid coincident with EMIT is dropped per REQ-023; in_valid in the cycle after EMIT (IDLE) is accepted.

Reset
REQ-025 n_rst low: state IDLE; buffers, sums, wptr, count, holding registers zero; out_x/y/z = 0, out_valid = 0, filled = 0, motion = 0, overrun = 0; takes effect immediately.
REQ-026 Reset asserted mid-sequence (AX..EMIT) aborts it; no out_valid is produced for the in-flight sample.
REQ-027 After n_rst deasserts, first accepted sample follows REQ-012 with no extra wait cycles.

Verification
REQ-028 Single sample in_x=800, in_y=-16, in_z=0 after reset -> out_valid 4 cycles later, out_x=100, out_y=-2, out_z=0, filled=0, motion=0.
REQ-029 Eight samples in_x=100 -> out_x sequence 12,25,37,50,62,75,87,100; filled=1 with 8th out_valid.
REQ-030 In_x=-1 single sample after reset -> out_x=-1 (floor rounding); then seven 0 samples -> out_x=-1 until 8th... 9th sample 0 evicts -1 -> out_x=0 (wrap-around).
REQ-031 Eight zero samples, then in_x=1024 -> out_x=128, motion=1; next sample 0 -> out_x=128, motion=0.
REQ-032 in_valid pulses at cycles N and N+2 -> one out_valid at N+4, overrun=1 from N+3 onward, second sample absent from sums.
REQ-033 n_rst pulsed low during AY of a sample -> no out_valid, all outputs 0; next sample in_x=80 -> out_x=10.
